// File: rtl/wb_pkg.sv
// Shared widths, default depth and the buffered write-back entry record.
package wb_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WB_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Youngest-match search over the stored write-back entries for operand forwarding.
module wb_lookup
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  wb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     head,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PW-1:0] idx;

  // Walk slots oldest to youngest so the last match wins; r0 never matches.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && (entries[idx].waddr == addr) && (addr != '0)) begin
        hit  = 1'b1;
        data = entries[idx].wdata;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: merges load and ALU write requests into an in-order buffer
// that drains to the register file write port, with pending-write lookup.
module wb_queue
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_waddr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  output logic              alu_ready,
  input  logic              hold,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  wb_entry_t        mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic [CW:0]      free;
  logic             deq;
  logic             ld_zero;
  logic             alu_zero;
  logic             ld_en;
  logic             alu_en;
  logic [DEPTH-1:0] vmask;
  logic [PW-1:0]    off;
  wb_entry_t        ld_entry;
  wb_entry_t        alu_entry;

  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign ld_zero  = (ld_waddr == '0);
  assign alu_zero = (alu_waddr == '0);
  assign ld_entry  = '{waddr: ld_waddr, wdata: ld_wdata};
  assign alu_entry = '{waddr: alu_waddr, wdata: alu_wdata};

  // Drain whenever something is buffered and the consumer is not stalling us.
  always_comb begin
    deq   = !empty && !hold;
    we    = deq;
    waddr = deq ? mem[rd_ptr].waddr : '0;
    wdata = deq ? mem[rd_ptr].wdata : '0;
  end

  // Free slots count the one being drained this cycle; r0 writes are always
  // accepted since they are dropped, and the load takes priority for one slot.
  always_comb begin
    free      = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(deq);
    ld_ready  = ld_zero || (free >= (CW+1)'(1));
    alu_ready = alu_zero
             || (free >= (CW+1)'(2))
             || ((free >= (CW+1)'(1)) && (!ld_valid || ld_zero));
    ld_en     = ld_valid  && ld_ready  && !ld_zero;
    alu_en    = alu_valid && alu_ready && !alu_zero;
  end

  // Slot i holds a live entry when its distance from the head is below count.
  always_comb begin
    vmask = '0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr;
      vmask[i] = (CW'(off) < count_q);
    end
  end

  // Entry storage carries no reset; liveness comes only from pointers and count.
  always_ff @(posedge clk) begin
    if (ld_en)  mem[wr_ptr] <= ld_entry;
    if (alu_en) mem[wr_ptr + PW'(ld_en)] <= alu_entry;
  end

  // Pointer and occupancy bookkeeping; the load lands first so the ALU entry is younger.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(ld_en) + PW'(alu_en);
      rd_ptr  <= rd_ptr + PW'(deq);
      count_q <= count_q + CW'(ld_en) + CW'(alu_en) - CW'(deq);
    end
  end

  wb_lookup #(.DEPTH(DEPTH)) u_lookup (
    .entries (mem),
    .valid   (vmask),
    .head    (rd_ptr),
    .addr    (lk_addr),
    .hit     (lk_hit),
    .data    (lk_data)
  );

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: stimulus pushes expected drains, a monitor
// pops and compares on every register file write.
module tb_wb_queue;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [4:0]  ld_waddr;
  logic [31:0] ld_wdata;
  logic        ld_ready;
  logic        alu_valid;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        alu_ready;
  logic        hold;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  lk_addr;
  logic        lk_hit;
  logic [31:0] lk_data;
  logic        full;
  logic        empty;
  logic [2:0]  count;

  int checks;
  int failures;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  wb_queue #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_waddr  (ld_waddr),
    .ld_wdata  (ld_wdata),
    .ld_ready  (ld_ready),
    .alu_valid (alu_valid),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .alu_ready (alu_ready),
    .hold      (hold),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .lk_addr   (lk_addr),
    .lk_hit    (lk_hit),
    .lk_data   (lk_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    ld_valid  = 1'b0;
    ld_waddr  = 5'd0;
    ld_wdata  = 32'd0;
    alu_valid = 1'b0;
    alu_waddr = 5'd0;
    alu_wdata = 32'd0;
  endtask

  task automatic drive_ld(input logic [4:0] a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_waddr = a;
    ld_wdata = d;
  endtask

  task automatic drive_alu(input logic [4:0] a, input logic [31:0] d);
    alu_valid = 1'b1;
    alu_waddr = a;
    alu_wdata = d;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!empty && n < 20) begin
      cyc();
      n++;
    end
    chk("drain_done", 32'(empty), 32'd1);
  endtask

  // Every register file write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      chk("we_in_reset", 32'(we), 32'd0);
    end else if (we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual waddr=%0d wdata=0x%0h required no write", waddr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("drain_waddr", 32'(waddr), 32'(mon_e[36:32]));
        chk("drain_wdata", wdata, mon_e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst      = 1'b0;
    hold     = 1'b0;
    lk_addr  = 5'd3;
    idle();
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_we",      32'(we),      32'd0);
    chk("rst_waddr",   32'(waddr),   32'd0);
    chk("rst_wdata",   wdata,        32'd0);
    chk("rst_lk_hit",  32'(lk_hit),  32'd0);
    chk("rst_lk_data", lk_data,      32'd0);
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_count",   32'(count),   32'd0);
    rst = 1'b1;

    // single write
    drive_ld(5'd3, 32'h11);
    exp_q.push_back({5'd3, 32'h11});
    settle();
    chk("single_ld_ready", 32'(ld_ready), 32'd1);
    chk("single_no_bypass", 32'(we), 32'd0);
    cyc();
    idle();
    settle();
    chk("single_count", 32'(count), 32'd1);
    chk("single_lk_head_hit", 32'(lk_hit), 32'd1);
    chk("single_lk_head_data", lk_data, 32'h11);
    cyc();
    settle();
    chk("single_empty", 32'(empty), 32'd1);
    cyc();

    // dual accept, youngest match forwarding
    lk_addr = 5'd4;
    drive_ld(5'd4, 32'hA);
    drive_alu(5'd4, 32'hB);
    exp_q.push_back({5'd4, 32'hA});
    exp_q.push_back({5'd4, 32'hB});
    settle();
    chk("dual_ld_ready", 32'(ld_ready), 32'd1);
    chk("dual_alu_ready", 32'(alu_ready), 32'd1);
    chk("dual_lk_excl_inputs", 32'(lk_hit), 32'd0);
    cyc();
    idle();
    settle();
    chk("dual_count", 32'(count), 32'd2);
    chk("dual_lk_hit", 32'(lk_hit), 32'd1);
    chk("dual_lk_young", lk_data, 32'hB);
    cyc();
    settle();
    chk("dual_lk_after_pop", lk_data, 32'hB);
    wait_empty();

    // fill under hold, then enqueue alongside the first drain
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_alu(5'(i), 32'h100 + 32'(i));
      exp_q.push_back({5'(i), 32'h100 + 32'(i)});
      settle();
      chk("fill_alu_ready", 32'(alu_ready), 32'd1);
      cyc();
    end
    drive_alu(5'd5, 32'h105);
    settle();
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_alu_blocked", 32'(alu_ready), 32'd0);
    chk("fill_hold_no_we", 32'(we), 32'd0);
    cyc();
    hold = 1'b0;
    exp_q.push_back({5'd5, 32'h105});
    settle();
    chk("fill_release_ready", 32'(alu_ready), 32'd1);
    chk("fill_release_we", 32'(we), 32'd1);
    cyc();
    idle();
    hold = 1'b1;
    settle();
    chk("fill_count_kept", 32'(count), 32'd4);
    chk("fill_still_full", 32'(full), 32'd1);
    cyc();

    // r0 discard while full; a real load is refused
    lk_addr = 5'd0;
    drive_alu(5'd0, 32'hFF);
    drive_ld(5'd20, 32'h20);
    settle();
    chk("r0_alu_ready", 32'(alu_ready), 32'd1);
    chk("full_ld_ready", 32'(ld_ready), 32'd0);
    chk("r0_lk_hit", 32'(lk_hit), 32'd0);
    chk("r0_lk_data", lk_data, 32'd0);
    cyc();
    idle();
    settle();
    chk("r0_count", 32'(count), 32'd4);
    cyc();
    hold = 1'b0;
    wait_empty();

    // one-slot conflict: load wins, ALU follows after release
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_alu(5'(6 + i), 32'h60 + 32'(i));
      exp_q.push_back({5'(6 + i), 32'h60 + 32'(i)});
      cyc();
    end
    drive_ld(5'd9, 32'h90);
    drive_alu(5'd10, 32'hA0);
    exp_q.push_back({5'd9, 32'h90});
    settle();
    chk("slot_count", 32'(count), 32'd3);
    chk("slot_ld_ready", 32'(ld_ready), 32'd1);
    chk("slot_alu_ready", 32'(alu_ready), 32'd0);
    cyc();
    ld_valid = 1'b0;
    hold = 1'b0;
    exp_q.push_back({5'd10, 32'hA0});
    settle();
    chk("slot_alu_after_release", 32'(alu_ready), 32'd1);
    cyc();
    idle();
    lk_addr = 5'd10;
    settle();
    chk("slot_lk_hit", 32'(lk_hit), 32'd1);
    chk("slot_lk_data", lk_data, 32'hA0);
    wait_empty();

    // reset mid-drain drops buffered entries
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_alu(5'(11 + i), 32'hB0 + 32'(i));
      cyc();
    end
    idle();
    chk("mid_count", 32'(count), 32'd3);
    hold = 1'b0;
    #1;
    chk("mid_we_before_rst", 32'(we), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_we", 32'(we), 32'd0);
    chk("mid_waddr", 32'(waddr), 32'd0);
    chk("mid_wdata", wdata, 32'd0);
    chk("mid_count_clr", 32'(count), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_full", 32'(full), 32'd0);
    lk_addr = 5'd11;
    #1;
    chk("mid_lk_hit", 32'(lk_hit), 32'd0);
    cyc();
    cyc();
    rst = 1'b1;
    repeat (6) cyc();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
